wb_pipe_stage: RTL

WB_PIPE_STAGE -- requirements
Module: wb_pipe_stage

---
 rtl/wb_pipe_stage_if.sv | 30 +++
 rtl/wb_pipe_stage.sv | 115 +++++++++++
 2 files changed

// File: rtl/wb_pipe_stage_if.sv
// Upstream handshake and register-file write bus of the writeback stage.
interface wb_pipe_stage_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned OPCD_W = 5
);
  logic              IN_VALID;
  logic              IN_READY;
  logic [DATA_W-1:0] DATA_IN;
  logic [OPCD_W-1:0] OPCD_IN;
  logic [ADDR_W-1:0] ADDR_REG_IN;
  logic              OPT_BIT_IN;
  logic [DATA_W-1:0] DATA_OUT;
  logic [ADDR_W-1:0] ADDR_REG_OUT;
  logic              OPT_BIT_OUT;
  logic              COND;
  logic              BUSY;
  logic [1:0]        ESTADO;
  logic [15:0]       RETIRED;

  modport master (
    output IN_VALID, DATA_IN, OPCD_IN, ADDR_REG_IN, OPT_BIT_IN,
    input  IN_READY, DATA_OUT, ADDR_REG_OUT, OPT_BIT_OUT, COND, BUSY, ESTADO, RETIRED
  );

  modport slave (
    input  IN_VALID, DATA_IN, OPCD_IN, ADDR_REG_IN, OPT_BIT_IN,
    output IN_READY, DATA_OUT, ADDR_REG_OUT, OPT_BIT_OUT, COND, BUSY, ESTADO, RETIRED
  );
endinterface

// File: rtl/wb_pipe_stage.sv
// Writeback pipeline stage: accepts one instruction per PHASES cycles and pulses COND.
// Optional macro WB_ZERO_REG_GUARD_EN suppresses the write enable for register 0.
module wb_pipe_stage #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned OPCD_W = 5,
  parameter int unsigned PHASES = 7
) (
  input logic           CLK,
  input logic           RST,
  wb_pipe_stage_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_WAIT  = 2'd2
  } state_e;

  localparam int unsigned CNT_W = 4;
  // WAIT lasts WAIT_LOAD+1 cycles, so IDLE+WRITE+WAIT sums to PHASES.
  localparam logic [CNT_W-1:0] WAIT_LOAD = (PHASES > 2) ? CNT_W'(PHASES - 3) : '0;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [OPCD_W-1:0] opcd_q, opcd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              opt_q, opt_d;
  logic [15:0]       retired_q, retired_d;
  logic              ready;
  logic              xfer;
  logic              addr_ok;

  function automatic logic op_writes(input logic [OPCD_W-1:0] op);
    return (op <= OPCD_W'(7)) || (op == OPCD_W'(9));
  endfunction

  assign ready = (state_q == S_IDLE);
  assign xfer  = bus.IN_VALID && ready;

`ifdef WB_ZERO_REG_GUARD_EN
  assign addr_ok = (addr_q != '0);
`else
  assign addr_ok = 1'b1;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    opcd_d    = opcd_q;
    addr_d    = addr_q;
    opt_d     = opt_q;
    retired_d = retired_q;
    case (state_q)
      S_IDLE: begin
        if (xfer) begin
          data_d    = bus.DATA_IN;
          opcd_d    = bus.OPCD_IN;
          addr_d    = bus.ADDR_REG_IN;
          opt_d     = bus.OPT_BIT_IN;
          retired_d = retired_q + 16'd1;
          state_d   = S_WRITE;
        end
      end
      S_WRITE: begin
        if (PHASES > 2) begin
          state_d = S_WAIT;
          cnt_d   = WAIT_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      data_q    <= '0;
      opcd_q    <= '0;
      addr_q    <= '0;
      opt_q     <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      opcd_q    <= opcd_d;
      addr_q    <= addr_d;
      opt_q     <= opt_d;
      retired_q <= retired_d;
    end
  end

  assign bus.IN_READY     = ready;
  assign bus.DATA_OUT     = data_q;
  assign bus.ADDR_REG_OUT = addr_q;
  assign bus.OPT_BIT_OUT  = opt_q;
  assign bus.COND         = (state_q == S_WRITE) && op_writes(opcd_q) && addr_ok;
  assign bus.BUSY         = (state_q != S_IDLE);
  assign bus.ESTADO       = state_q;
  assign bus.RETIRED      = retired_q;

endmodule
